// File: rtl/load_store_unit.sv
// Memory-access stage: issues one byte/halfword/word load or store on a req/ready
// bus, stalls the pipeline while it is outstanding and returns the extended load data.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] ALUout,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Stall,
  output logic                  Done,
  output logic                  AccessErr,
  output logic                  BusErr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [CW-1:0]           count;
  logic [2:0]              f3_q;
  logic [1:0]              ofs_q;

  logic                    req, f3_ok, misalign, illegal, legal;
  logic [3:0]              be_n;
  logic [DATA_WIDTH-1:0]   wdata_n;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   load_ext;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned and infers a latch.
  always_comb begin
    req      = MemRead | MemWrite;
    f3_ok    = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misalign = ((funct3[1:0] == 2'b01) && ALUout[0]) ||
               ((funct3 == 3'b010) && (ALUout[1:0] != 2'b00));
    illegal  = req && ((MemRead && MemWrite) || !f3_ok || (MemWrite && funct3[2]) || misalign);
    legal    = req && !illegal;

    be_n    = 4'b1111;
    wdata_n = WriteData;
    case (funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << ALUout[1:0];
        wdata_n = {4{WriteData[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << ALUout[1:0];
        wdata_n = {2{WriteData[15:0]}};
      end
      default: ;
    endcase

    lane     = mem_rdata >> {ofs_q, 3'b000};
    load_ext = mem_rdata;
    case (f3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_ext = {24'b0, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_ext = {16'b0, lane[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Stall must rise in the request cycle itself and fall at once when reset hits.
  assign Stall = rst_n && (((state == IDLE) && legal) || (state == BUSY));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      f3_q      <= '0;
      ofs_q     <= '0;
      ReadData  <= '0;
      Done      <= 1'b0;
      AccessErr <= 1'b0;
      BusErr    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
    end else begin
      Done      <= 1'b0;
      AccessErr <= 1'b0;
      BusErr    <= 1'b0;
      case (state)
        IDLE: begin
          if (illegal) begin
            AccessErr <= 1'b1;
          end else if (legal) begin
            state     <= BUSY;
            count     <= '0;
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= {ALUout[DATA_WIDTH-1:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
            f3_q      <= funct3;
            ofs_q     <= ALUout[1:0];
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (!mem_we) ReadData <= load_ext;
            state   <= DONE;
            mem_req <= 1'b0;
            Done    <= 1'b1;
          end else if (count == CW'(TIMEOUT_CYCLES - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            Done    <= 1'b1;
            BusErr  <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, illegal requests, timeout
// and reset-in-BUSY, each checked against hand-computed values.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUout, WriteData, ReadData;
  logic        Stall, Done, AccessErr, BusErr;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_ready;

  int compared   = 0;
  int mismatched = 0;

  // observations gathered by run_access
  int          stall_cnt;
  logic        done_seen, buserr_seen, req_seen, we_seen;
  logic [31:0] addr_seen, wdata_seen;
  logic [3:0]  be_seen;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .ALUout(ALUout), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .Done(Done), .AccessErr(AccessErr), .BusErr(BusErr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, answer it after `waits` BUSY cycles (waits > 20 means never).
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int waits);
    stall_cnt   = 0;
    done_seen   = 1'b0;
    buserr_seen = 1'b0;
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUout = addr; WriteData = wd;
    #1;
    if (Stall) stall_cnt++;
    tick();
    MemRead = 1'b0; MemWrite = 1'b0; ALUout = 32'hDEAD_0000;
    for (int k = 0; k < 40; k++) begin
      if (Done) begin
        done_seen   = 1'b1;
        buserr_seen = BusErr;
        break;
      end
      if (k == 0) begin
        req_seen   = mem_req;
        we_seen    = mem_we;
        addr_seen  = mem_addr;
        be_seen    = mem_be;
        wdata_seen = mem_wdata;
      end
      if (Stall) stall_cnt++;
      mem_rdata = rdata;
      mem_ready = (k == waits);
      tick();
      mem_ready = 1'b0;
    end
  endtask

  task automatic run_illegal(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
    MemRead = rd; MemWrite = wr; funct3 = f3; ALUout = addr;
    #1;
    check({tag, "_stall"}, 32'(Stall), 32'd0);
    tick();
    MemRead = 1'b0; MemWrite = 1'b0;
    check({tag, "_err"}, 32'(AccessErr), 32'd1);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    tick();
    check({tag, "_err_low"}, 32'(AccessErr), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'b000;
    ALUout = '0; WriteData = '0; mem_rdata = '0; mem_ready = 1'b0;
    #23;
    check("rst_readdata", ReadData, 32'h0);
    check("rst_stall", 32'(Stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    tick();

    // LW with three wait cycles
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 3);
    check("lw_done", 32'(done_seen), 32'd1);
    check("lw_req", 32'(req_seen), 32'd1);
    check("lw_addr", addr_seen, 32'h100);
    check("lw_be", 32'(be_seen), 32'hF);
    check("lw_stall", 32'(stall_cnt), 32'd5);
    check("lw_data", ReadData, 32'h1234_5678);
    check("lw_buserr", 32'(buserr_seen), 32'd0);
    tick();
    check("lw_done_pulse", 32'(Done), 32'd0);

    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h8012_3456, 0);
    check("lb_be", 32'(be_seen), 32'h8);
    check("lb_stall", 32'(stall_cnt), 32'd2);
    check("lb_data", ReadData, 32'hFFFF_FF80);
    tick();

    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h8012_3456, 0);
    check("lbu_data", ReadData, 32'h0000_0080);
    tick();

    run_access(1'b1, 1'b0, 3'b101, 32'h202, 32'h0, 32'hBEEF_1234, 0);
    check("lhu_be", 32'(be_seen), 32'hC);
    check("lhu_data", ReadData, 32'h0000_BEEF);
    tick();

    run_access(1'b1, 1'b0, 3'b001, 32'h202, 32'h0, 32'hBEEF_1234, 0);
    check("lh_data", ReadData, 32'hFFFF_BEEF);
    tick();

    run_access(1'b0, 1'b1, 3'b000, 32'h301, 32'hAABB_CCDD, 32'h1111_1111, 0);
    check("sb_we", 32'(we_seen), 32'd1);
    check("sb_be", 32'(be_seen), 32'h2);
    check("sb_wdata", wdata_seen, 32'hDDDD_DDDD);
    check("sb_addr", addr_seen, 32'h300);
    check("sb_readdata", ReadData, 32'hFFFF_BEEF);
    tick();

    run_illegal("ill_lw_mis", 1'b1, 1'b0, 3'b010, 32'h402);
    run_illegal("ill_rw", 1'b1, 1'b1, 3'b010, 32'h400);
    run_illegal("ill_sbu", 1'b0, 1'b1, 3'b100, 32'h400);

    // memory never answers: 16 BUSY cycles then abort
    run_access(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h5555_5555, 99);
    check("to_done", 32'(done_seen), 32'd1);
    check("to_buserr", 32'(buserr_seen), 32'd1);
    check("to_stall", 32'(stall_cnt), 32'd17);
    check("to_readdata", ReadData, 32'hFFFF_BEEF);
    tick();
    check("to_buserr_low", 32'(BusErr), 32'd0);

    // reset in the middle of BUSY
    MemRead = 1'b1; funct3 = 3'b010; ALUout = 32'h700;
    tick();
    MemRead = 1'b0;
    tick();
    check("rb_req_busy", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_req", 32'(mem_req), 32'd0);
    check("rb_stall", 32'(Stall), 32'd0);
    check("rb_readdata", ReadData, 32'h0);
    check("rb_addr", mem_addr, 32'h0);
    check("rb_be", 32'(mem_be), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("rb_idle_stall", 32'(Stall), 32'd0);
    check("rb_idle_req", 32'(mem_req), 32'd0);

    run_access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0, 32'hCAFE_BABE, 0);
    check("post_rst_data", ReadData, 32'hCAFE_BABE);
    check("post_rst_stall", 32'(stall_cnt), 32'd2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the execute-stage ALU.
- Takes the ALU result as the effective address, plus store data and funct3 from the execute stage.
- Performs one byte/halfword/word load or store over a simple req/ready data-memory bus.
- Returns the sign- or zero-extended load result and stalls the pipeline while the access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and address width; only 32 is supported.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles without mem_ready before the access is aborted.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- MemRead  input  1  load request from the execute stage.
- MemWrite  input  1  store request from the execute stage.
- funct3  input  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUout  input  DATA_WIDTH  effective byte address.
- WriteData  input  DATA_WIDTH  store data, taken from the low bits.
- ReadData  output  DATA_WIDTH  extended load result, registered.
- Stall  output  1  holds the pipeline while an access is in progress.
- Done  output  1  one-cycle pulse when an access completes or aborts.
- AccessErr  output  1  one-cycle pulse for a misaligned or illegal access.
- BusErr  output  1  one-cycle pulse on timeout abort.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  DATA_WIDTH  word-aligned address, {addr[31:2],2'b00}.
- mem_be  output  4  byte enables.
- mem_wdata  output  DATA_WIDTH  lane-replicated store data.
- mem_rdata  input  DATA_WIDTH  read data, valid when mem_ready=1.
- mem_ready  input  1  completes the current request.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - ReadData=0, Done=0, AccessErr=0, BusErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0.
  - Stall=0.
  - Reset asserted in BUSY abandons the request; mem_req drops immediately (asynchronously).
- States: IDLE, BUSY, DONE.
- IDLE:
  - Request = MemRead|MemWrite.
  - Illegal if any of the following:
    - MemRead and MemWrite are both 1.
    - funct3 is not in {000,001,010,100,101}.
    - funct3 is 100 or 101 on a store.
    - H/HU with addr[0]=1.
    - W with addr[1:0]!=0.
  - Illegal request: AccessErr pulses the next cycle, no bus activity, Stall=0, stay IDLE.
  - Legal request: Stall=1 combinationally in the same cycle; latch addr, funct3, MemWrite and WriteData; clear the counter; go to BUSY.
- BUSY:
  - mem_req=1 and Stall=1.
  - mem_addr, mem_we, mem_be and mem_wdata are held constant from the latched values.
  - Byte enables and write data:
    - B: mem_be = 0001<<addr[1:0]; mem_wdata = {4{WriteData[7:0]}}.
    - H: mem_be = 0011<<addr[1:0]; mem_wdata = {2{WriteData[15:0]}}.
    - W: mem_be = 1111; mem_wdata = WriteData.
    - Loads drive the same mem_be.
  - mem_ready=1:
    - For a load, ReadData <= lane = mem_rdata >> (8*addr[1:0]).
    - B: sign-extend lane[7:0]. BU: zero-extend lane[7:0]. H: sign-extend lane[15:0]. HU: zero-extend lane[15:0]. W: mem_rdata.
    - For a store, ReadData is unchanged.
    - Go to DONE.
  - mem_ready=0: counter increments. When the counter reaches TIMEOUT_CYCLES-1 without ready:
    - BusErr pulses in DONE.
    - ReadData unchanged.
    - Go to DONE.
  - MemRead/MemWrite/ALUout changes during BUSY are ignored.
- DONE:
  - Stall=0, mem_req=0, Done=1 for exactly one cycle.
  - Unconditionally return to IDLE.
  - Request inputs visible in DONE are the completing instruction and are not re-issued.
- Latency: zero-wait memory (ready in the first BUSY cycle) gives Stall high for 2 cycles and Done in the 3rd cycle. Each wait cycle adds 1.
- Pulses: Done, AccessErr and BusErr are each registered, one cycle wide, and never high two consecutive cycles for one access.
- Throughput: back-to-back accesses have at least one IDLE cycle between DONE and the next BUSY.

Test Plan:
- LW, addr 0x100, mem_rdata 0x12345678, ready after 3 wait cycles -> mem_addr 0x100, mem_be 1111, Stall high for 5 cycles, Done pulse, ReadData 0x12345678.
- LB, addr 0x103, mem_rdata 0x80123456, zero-wait -> mem_be 1000, ReadData 0xFFFFFF80. Repeat with LBU -> 0x00000080.
- LHU, addr 0x202, mem_rdata 0xBEEF1234 -> mem_be 1100, ReadData 0x0000BEEF. Repeat with LH -> 0xFFFFBEEF.
- SB, addr 0x301, WriteData 0xAABBCCDD -> mem_we 1, mem_be 0010, mem_wdata 0xDDDDDDDD, mem_addr 0x300, ReadData unchanged.
- Illegal requests produce no mem_req, no Stall, and AccessErr one cycle later:
  - LW at addr 0x402.
  - MemRead&MemWrite both 1.
  - Store with funct3=100.
- Timeout and reset:
  - mem_ready held 0 -> BusErr and Done pulse after TIMEOUT_CYCLES BUSY cycles, ReadData unchanged.
  - Second run: assert rst_n=0 in BUSY -> mem_req and Stall drop immediately, all outputs 0, IDLE after release.
